// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer on the PLL reference clock: pulses pll_reset, waits for lock with timeout and retry,
// qualifies lock as stable, then releases sys_reset. Define PLL_SUP_FAULT_EN to add a terminal FAULT state.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 40000,
    parameter int LOCK_STABLE    = 4000,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       lock_lost,
    output logic       fault
);

    if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 65535) begin : g_bad_rst_cycles
        $error("PLL_RST_CYCLES out of range 1..65535");
    end
    if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_bad_timeout
        $error("LOCK_TIMEOUT out of range 2..65535");
    end
    if (LOCK_STABLE < 1 || LOCK_STABLE > 65535) begin : g_bad_stable
        $error("LOCK_STABLE out of range 1..65535");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
        $error("MAX_RETRIES out of range 1..15");
    end

    localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);

`ifdef PLL_SUP_FAULT_EN
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sync1_q, sync1_d;
    logic        lock_s_q, lock_s_d;
    logic [3:0]  retry_q, retry_d;
    logic        lock_lost_q, lock_lost_d;
    logic        pll_reset_q, pll_reset_d;
    logic        sys_reset_q, sys_reset_d;
    logic        ready_q, ready_d;
    logic        retry_req;
`ifdef PLL_SUP_FAULT_EN
    logic        fault_q, fault_d;
`endif

    always_comb begin
        sync1_d     = pll_lock;
        lock_s_d    = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;
        retry_req   = 1'b0;

        case (state_q)
            ST_RST_PLL: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_d = cnt_q + 16'd1;
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_RST_PLL;
                    retry_req = 1'b1;
                end
            end
            ST_STABLE: begin
                cnt_d = cnt_q + 16'd1;
                // Any loss during qualification restarts the wait without spending a retry.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d     = ST_RST_PLL;
                    lock_lost_d = 1'b1;
                    retry_req   = 1'b1;
                end
            end
`ifdef PLL_SUP_FAULT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_RST_PLL;
        endcase

        if (retry_req) begin
`ifdef PLL_SUP_FAULT_EN
            if (retry_q >= RETRY_MAX) state_d = ST_FAULT;
            else                      retry_d = retry_q + 4'd1;
`else
            if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
`endif
        end

        if (state_d != state_q) cnt_d = '0;

        // Outputs follow the next state so they move on the same edge as the state.
`ifdef PLL_SUP_FAULT_EN
        pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
        fault_d     = (state_d == ST_FAULT);
`else
        pll_reset_d = (state_d == ST_RST_PLL);
`endif
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST_PLL;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
`ifdef PLL_SUP_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
`ifdef PLL_SUP_FAULT_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lock_lost_q;
`ifdef PLL_SUP_FAULT_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output vectors are pushed per edge from timing formulas.
module tb_pll_lock_supervisor;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int LOCK_STABLE    = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int PERIOD         = PLL_RST_CYCLES + LOCK_TIMEOUT;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_reset, ready, lock_lost, fault;
    logic [3:0] retry_cnt;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_reset(sys_reset),
        .ready    (ready),
        .retry_cnt(retry_cnt),
        .lock_lost(lock_lost),
        .fault    (fault)
    );

    always #5 clkin = ~clkin;

    // Vector layout: {pll_reset, sys_reset, ready, lock_lost, fault, retry_cnt}
    function automatic logic [8:0] pack(input logic pr, input logic sr, input logic rd,
                                        input logic ll, input logic f, input logic [3:0] rc);
        return {pr, sr, rd, ll, f, rc};
    endfunction

    function automatic logic [8:0] observed();
        return {pll_reset, sys_reset, ready, lock_lost, fault, retry_cnt};
    endfunction

    task automatic tick(input logic l);
        @(negedge clkin);
        pll_lock = l;
        @(posedge clkin);
        #1;
    endtask

    task automatic start_seq();
        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (2) @(posedge clkin);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] got, want;
        @(negedge clkin);
        reset = 1'b1;
        #1;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        got  = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", got, want);
        end
        repeat (3) @(posedge clkin);
        #1;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        got  = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", got, want);
        end
    endtask

    task automatic test_clean_start();
        logic [8:0] got, want;
        start_seq();
        for (int e = 1; e <= 26; e++) begin
            exp_q.push_back(pack(e < 4, e < 20, e >= 20, 1'b0, 1'b0, 4'd0));
            tick(e >= 10);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clean_start edge %0d: got %b want %b", e, got, want);
            end
        end
    endtask

`ifdef PLL_SUP_FAULT_EN
    task automatic test_fault();
        logic [8:0] got, want;
        int fault_edge;
        fault_edge = (MAX_RETRIES + 1) * PERIOD;
        start_seq();
        for (int e = 1; e <= fault_edge + 40; e++) begin
            if (e >= fault_edge)
                exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(MAX_RETRIES)));
            else
                exp_q.push_back(pack((e % PERIOD) < PLL_RST_CYCLES, 1'b1, 1'b0, 1'b0, 1'b0,
                                     4'(e / PERIOD)));
            tick(1'b0);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fault_seq edge %0d: got %b want %b", e, got, want);
            end
        end
        @(negedge clkin);
        reset = 1'b1;
        #1;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        got  = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL fault_cleared: got %b want %b", got, want);
        end
    endtask
`else
    task automatic test_no_lock();
        logic [8:0] got, want;
        int k;
        start_seq();
        for (int e = 1; e <= 16 * PERIOD + 8; e++) begin
            k = e / PERIOD;
            exp_q.push_back(pack((e % PERIOD) < PLL_RST_CYCLES, 1'b1, 1'b0, 1'b0, 1'b0,
                                 4'(k > 15 ? 15 : k)));
            tick(1'b0);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL no_lock edge %0d: got %b want %b", e, got, want);
            end
        end
    endtask
`endif

    task automatic test_lock_bounce();
        logic [8:0] got, want;
        logic lk;
        start_seq();
        for (int e = 1; e <= 32; e++) begin
            lk = (e >= 10 && e <= 14) || (e >= 16);
            exp_q.push_back(pack(e < 4, e < 26, e >= 26, 1'b0, 1'b0, 4'd0));
            tick(lk);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lock_bounce edge %0d: got %b want %b", e, got, want);
            end
        end
    endtask

    // Runs the loss-in-RUN scenario up to last_edge; lock drops for edges 26..28.
    task automatic run_loss(input int last_edge, input string tag);
        logic [8:0] got, want;
        logic lk, run, pr;
        for (int e = 1; e <= last_edge; e++) begin
            lk  = (e >= 10) && !(e >= 26 && e <= 28);
            run = (e >= 20 && e < 28) || (e >= 41);
            pr  = (e < 4) || (e >= 28 && e < 32);
            exp_q.push_back(pack(pr, !run, run, e >= 28, 1'b0, (e >= 28) ? 4'd1 : 4'd0));
            tick(lk);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s edge %0d: got %b want %b", tag, e, got, want);
            end
        end
    endtask

    task automatic test_loss_in_run();
        start_seq();
        run_loss(50, "loss_in_run");
    endtask

    task automatic test_async_reset();
        logic [8:0] got, want;
        start_seq();
        run_loss(38, "pre_async");
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        got  = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want %b", got, want);
        end
        start_seq();
        for (int e = 1; e <= 24; e++) begin
            exp_q.push_back(pack(e < 4, e < 20, e >= 20, 1'b0, 1'b0, 4'd0));
            tick(e >= 10);
            got  = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rerun edge %0d: got %b want %b", e, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_start();
`ifdef PLL_SUP_FAULT_EN
        test_fault();
`else
        test_no_lock();
`endif
        test_lock_bounce();
        test_loss_in_run();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
